// File: rtl/remote_comm.sv
// remote_comm: host-side command sender and response receiver for the Knight.
// A 16-bit command goes out on TX as two 8N1 bytes, high byte first; the
// 8-bit response coming back on RX is deserialized into resp.
//
// TX FSM
//   state   | meaning
//   TX_IDLE | line idle high, waiting for snd_cmd
//   TX_HIGH | shifting start/data/stop of cmd[15:8]
//   TX_LOW  | shifting start/data/stop of cmd[7:0]
//   TX_DONE | one-cycle cmd_snt pulse, still busy
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | counting to mid start bit to reject glitches
//   RX_DATA  | sampling 8 data bits at mid-bit, LSB first
//   RX_STOP  | sampling the stop bit; publish byte only if it is high
module remote_comm #(
  parameter int BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        busy,
  output logic        cmd_snt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW, TX_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t       tx_state, tx_state_nxt;
  logic [BW-1:0]   tx_baud, tx_baud_nxt;
  logic [3:0]      tx_bit, tx_bit_nxt;
  logic [15:0]     tx_shadow, tx_shadow_nxt;
  logic            tx_q, tx_q_nxt;
  logic [7:0]      tx_byte;
  logic [2:0]      tx_idx;

  rx_state_t       rx_state, rx_state_nxt;
  logic [BW-1:0]   rx_baud, rx_baud_nxt;
  logic [3:0]      rx_bit, rx_bit_nxt;
  logic [7:0]      rx_shift, rx_shift_nxt;
  logic [7:0]      resp_q, resp_nxt;
  logic            resp_rdy_q, resp_rdy_nxt;
  logic            rx_meta, rx_sync, rx_prev;

  assign busy     = (tx_state != TX_IDLE);
  assign cmd_snt  = (tx_state == TX_DONE);
  assign TX       = tx_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

  // TX next state, bit timing, and the registered line level for the next cycle
  always_comb begin
    tx_state_nxt  = tx_state;
    tx_baud_nxt   = tx_baud;
    tx_bit_nxt    = tx_bit;
    tx_shadow_nxt = tx_shadow;
    tx_q_nxt      = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (snd_cmd) begin
          tx_state_nxt  = TX_HIGH;
          tx_baud_nxt   = BAUD_LAST;
          tx_bit_nxt    = 4'd0;
          tx_shadow_nxt = cmd;
        end
      end
      TX_HIGH, TX_LOW: begin
        if (tx_baud == '0) begin
          tx_baud_nxt = BAUD_LAST;
          if (tx_bit == 4'd9) begin
            tx_bit_nxt   = 4'd0;
            tx_state_nxt = (tx_state == TX_HIGH) ? TX_LOW : TX_DONE;
          end else begin
            tx_bit_nxt = tx_bit + 4'd1;
          end
        end else begin
          tx_baud_nxt = tx_baud - BAUD_ONE;
        end
      end
      TX_DONE: tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
    // Registering the line avoids decode glitches on the pin; it is computed
    // from next-state values so the start bit still appears right after accept.
    tx_byte = (tx_state_nxt == TX_HIGH) ? tx_shadow_nxt[15:8] : tx_shadow_nxt[7:0];
    tx_idx  = 3'(tx_bit_nxt - 4'd1);
    if (tx_state_nxt == TX_HIGH || tx_state_nxt == TX_LOW) begin
      if (tx_bit_nxt == 4'd0)      tx_q_nxt = 1'b0;
      else if (tx_bit_nxt == 4'd9) tx_q_nxt = 1'b1;
      else                         tx_q_nxt = tx_byte[tx_idx];
    end
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_baud   <= '0;
      tx_bit    <= 4'd0;
      tx_shadow <= 16'h0000;
      tx_q      <= 1'b1;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_baud   <= tx_baud_nxt;
      tx_bit    <= tx_bit_nxt;
      tx_shadow <= tx_shadow_nxt;
      tx_q      <= tx_q_nxt;
    end
  end

  // RX line synchronizer plus one more flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX next state, mid-bit sampling and response publish
  always_comb begin
    rx_state_nxt = rx_state;
    rx_baud_nxt  = rx_baud;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    resp_nxt     = resp_q;
    resp_rdy_nxt = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_nxt = RX_START;
          rx_baud_nxt  = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_baud == '0) begin
          if (rx_sync) begin
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_state_nxt = RX_DATA;
            rx_baud_nxt  = BAUD_LAST;
            rx_bit_nxt   = 4'd0;
          end
        end else begin
          rx_baud_nxt = rx_baud - BAUD_ONE;
        end
      end
      RX_DATA: begin
        if (rx_baud == '0) begin
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          rx_baud_nxt  = BAUD_LAST;
          if (rx_bit == 4'd7) begin
            rx_bit_nxt   = 4'd0;
            rx_state_nxt = RX_STOP;
          end else begin
            rx_bit_nxt = rx_bit + 4'd1;
          end
        end else begin
          rx_baud_nxt = rx_baud - BAUD_ONE;
        end
      end
      RX_STOP: begin
        if (rx_baud == '0) begin
          // Leaving at mid-stop keeps half a bit of margin for a back-to-back start.
          rx_state_nxt = RX_IDLE;
          if (rx_sync) begin
            resp_nxt     = rx_shift;
            resp_rdy_nxt = 1'b1;
          end
        end else begin
          rx_baud_nxt = rx_baud - BAUD_ONE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_baud    <= '0;
      rx_bit     <= 4'd0;
      rx_shift   <= 8'h00;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_state   <= rx_state_nxt;
      rx_baud    <= rx_baud_nxt;
      rx_bit     <= rx_bit_nxt;
      rx_shift   <= rx_shift_nxt;
      resp_q     <= resp_nxt;
      resp_rdy_q <= resp_rdy_nxt;
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: stimulus pushes expected TX bytes,
// cmd_snt cycles and responses; monitors decode the DUT outputs and compare.
module tb_remote_comm;

  localparam int B     = 16;
  localparam int FRAME = 20 * B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        busy, cmd_snt, TX;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;

  assign RX = loop_en ? TX : rx_drv;

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd),
    .busy(busy), .cmd_snt(cmd_snt), .TX(TX), .RX(RX),
    .resp(resp), .resp_rdy(resp_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_tx[$];
  int         exp_snt[$];
  logic [7:0] exp_resp[$];

  // Reference model of the sender: one frame of FRAME cycles after each accept.
  int  acc_cyc = 0;
  bit  acc_valid = 1'b0;
  bit  mon_en = 1'b0;
  int  rst_cnt = 0;

  logic       dec_prev = 1'b1;
  logic [7:0] dec_data;
  logic       dec_start, dec_stop;
  int         dec_r0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_busy(input int c);
    return acc_valid && (c >= acc_cyc) && (c <= acc_cyc + FRAME);
  endfunction

  always @(negedge clk) if (!rst_n) rst_cnt++;

  // Output monitor: busy every cycle, cmd_snt and resp_rdy against the queues
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", {31'd0, busy}, {31'd0, model_busy(cyc)});
      if (cmd_snt !== 1'b0) begin
        if (exp_snt.size() == 0) check("cmd_snt_unexpected", {31'd0, cmd_snt}, 32'd0);
        else check("cmd_snt_cycle", cyc, exp_snt.pop_front());
      end
      if (resp_rdy !== 1'b0) begin
        if (exp_resp.size() == 0) check("resp_rdy_unexpected", {31'd0, resp_rdy}, 32'd0);
        else check("resp", {24'd0, resp}, {24'd0, exp_resp.pop_front()});
      end
    end
  end

  // TX line decoder: samples each 8N1 bit at mid-bit; frames cut by reset are dropped
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && dec_prev === 1'b1 && TX === 1'b0) begin
        dec_r0 = rst_cnt;
        repeat (B / 2) @(negedge clk);
        dec_start = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          dec_data[i] = TX;
        end
        repeat (B) @(negedge clk);
        dec_stop = TX;
        if (rst_cnt == dec_r0) begin
          check("tx_start_bit", {31'd0, dec_start}, 32'd0);
          check("tx_stop_bit", {31'd0, dec_stop}, 32'd1);
          check("tx_byte_expected", exp_tx.size() > 0, 32'd1);
          if (exp_tx.size() > 0)
            check("tx_byte", {24'd0, dec_data}, {24'd0, exp_tx.pop_front()});
        end
      end
      dec_prev = TX;
    end
  end

  task automatic try_send(input logic [15:0] c);
    int l;
    bit acc;
    @(negedge clk);
    l = cyc;
    cmd = c;
    snd_cmd = 1'b1;
    acc = !(acc_valid && (l <= acc_cyc + FRAME));
    @(posedge clk);
    if (acc) begin
      acc_cyc   = l + 1;
      acc_valid = 1'b1;
      exp_tx.push_back(c[15:8]);
      exp_tx.push_back(c[7:0]);
      exp_snt.push_back(l + 1 + FRAME);
    end
    @(negedge clk);
    snd_cmd = 1'b0;
    cmd = 16'($urandom);
    if (acc) check("tx_start_after_accept", {31'd0, TX}, 32'd0);
  endtask

  task automatic wait_tx_idle();
    while (acc_valid && (cyc <= acc_cyc + FRAME)) @(negedge clk);
  endtask

  // Drives one 8N1 byte on RX starting at the current negedge
  task automatic send_rx(input logic [7:0] b, input logic stop);
    if (stop) exp_resp.push_back(b);
    rx_drv = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (B) @(negedge clk);
    end
    rx_drv = stop;
    repeat (B) @(negedge clk);
    rx_drv = 1'b1;
    if (!stop) repeat (B) @(negedge clk);
  endtask

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exceeded");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, TX}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    check("reset_resp", {24'd0, resp}, 32'd0);
    check("reset_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // command send with mid-frame snd_cmd attempts that must be dropped
    try_send(16'h2D37);
    repeat (100) @(negedge clk);
    try_send(16'hFFFF);
    repeat (100) @(negedge clk);
    try_send(16'h0F0F);
    wait_tx_idle();
    repeat (B) @(negedge clk);

    // back-to-back responses
    send_rx(8'hA5, 1'b1);
    send_rx(8'h5A, 1'b1);
    repeat (2 * B) @(negedge clk);
    check("resp_after_pair", {24'd0, resp}, 32'h5A);
    check("rx_pair_drained", exp_resp.size(), 32'd0);

    // framing error and a short glitch leave resp alone
    send_rx(8'h3C, 1'b0);
    repeat (2 * B) @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * B) @(negedge clk);
    check("resp_after_errors", {24'd0, resp}, 32'h5A);

    // reset while the low byte is shifting
    try_send(16'h1234);
    while (cyc < acc_cyc + 10 * B + 40) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    acc_valid = 1'b0;
    exp_tx.delete();
    exp_snt.delete();
    @(negedge clk);
    check("midframe_reset_tx", {31'd0, TX}, 32'd1);
    check("midframe_reset_busy", {31'd0, busy}, 32'd0);
    check("midframe_reset_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    check("midframe_reset_resp", {24'd0, resp}, 32'd0);
    rst_n = 1'b1;
    repeat (12 * B) @(negedge clk);
    try_send(16'h0001);
    wait_tx_idle();
    repeat (B) @(negedge clk);

    // loopback TX into RX
    loop_en = 1'b1;
    exp_resp.push_back(8'hA5);
    exp_resp.push_back(8'h5A);
    try_send(16'hA55A);
    wait_tx_idle();
    repeat (B) @(negedge clk);
    loop_en = 1'b0;
    check("loop_resp_drained", exp_resp.size(), 32'd0);
    check("loop_resp", {24'd0, resp}, 32'h5A);

    // randomized concurrent send and receive
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          wait_tx_idle();
          repeat ($urandom_range(0, 6)) @(negedge clk);
          try_send(16'($urandom));
          repeat ($urandom_range(5, 330)) @(negedge clk);
          try_send(16'($urandom));
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          repeat ($urandom_range(0, 20)) @(negedge clk);
          send_rx(8'($urandom), ($urandom_range(0, 4) != 0));
        end
      end
    join
    wait_tx_idle();
    repeat (12 * B) @(negedge clk);

    check("final_tx_queue", exp_tx.size(), 32'd0);
    check("final_snt_queue", exp_snt.size(), 32'd0);
    check("final_resp_queue", exp_resp.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
